// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: deglitch, deframe, fold E0/F0 prefixes,
// and queue key events in a small first-word-fall-through FIFO.
module ps2_scancode_rx #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 25000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   output logic       valid,
   output logic [7:0] code,
   output logic       released,
   output logic       extended,
   output logic       frame_err,
   output logic       overflow
);

   localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // bit 0 carries ps2_clk, bit 1 carries ps2_data
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    filt_q;
   logic [FW-1:0] fcnt_q [2];
   logic          kclk_prev_q;
   logic          bit_ev;
   logic          kdat;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         sync1_q     <= 2'b11;
         sync2_q     <= 2'b11;
         filt_q      <= 2'b11;
         fcnt_q[0]   <= '0;
         fcnt_q[1]   <= '0;
         kclk_prev_q <= 1'b1;
      end else begin
         sync1_q     <= {ps2_data, ps2_clk};
         sync2_q     <= sync1_q;
         kclk_prev_q <= filt_q[0];
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
               filt_q[i] <= sync2_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + FW'(1);
            end
         end
      end
   end

   assign bit_ev = kclk_prev_q & ~filt_q[0];
   assign kdat   = filt_q[1];

   state_t        state_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic          par_q;
   logic [TW-1:0] to_cnt_q;
   logic          ext_pend_q;
   logic          brk_pend_q;
   logic          push_q;
   logic [9:0]    push_data_q;
   logic          frame_err_q;
   logic          timed_out;

   assign timed_out = (state_q != S_IDLE) && !bit_ev &&
                      (to_cnt_q == TW'(TIMEOUT));

   // Deframing and prefix folding share one cycle so a good stop bit
   // becomes a push request on the very next edge.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         ext_pend_q  <= 1'b0;
         brk_pend_q  <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         frame_err_q <= 1'b0;
      end else begin
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;

         if (state_q == S_IDLE || bit_ev) begin
            to_cnt_q <= '0;
         end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
         end

         if (timed_out) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b1;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
         end else if (bit_ev) begin
            case (state_q)
               S_IDLE: begin
                  if (!kdat) begin
                     state_q   <= S_DATA;
                     bit_cnt_q <= '0;
                  end else begin
                     frame_err_q <= 1'b1;
                     ext_pend_q  <= 1'b0;
                     brk_pend_q  <= 1'b0;
                  end
               end
               S_DATA: begin
                  shift_q   <= {kdat, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= S_PARITY;
                  end
               end
               S_PARITY: begin
                  par_q   <= kdat;
                  state_q <= S_STOP;
               end
               S_STOP: begin
                  state_q <= S_IDLE;
                  if (kdat && ((^shift_q) ^ par_q)) begin
                     if (shift_q == 8'hE0) begin
                        ext_pend_q <= 1'b1;
                     end else if (shift_q == 8'hF0) begin
                        brk_pend_q <= 1'b1;
                     end else begin
                        push_q      <= 1'b1;
                        push_data_q <= {ext_pend_q, brk_pend_q, shift_q};
                        ext_pend_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     ext_pend_q  <= 1'b0;
                     brk_pend_q  <= 1'b0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          valid_q;
   logic [9:0]    head_q;
   logic          overflow_q;

   logic          pop;
   logic          full;
   logic          wr_ok;
   logic          ovf_d;
   logic [CW-1:0] count_d;
   logic [AW-1:0] rd_ptr_d;
   logic [9:0]    head_d;

   // The head is registered from next-state pointers so the outputs hold
   // their last value once the FIFO drains.
   always_comb begin
      pop      = rd_en & valid_q;
      full     = (count_q == CW'(FIFO_DEPTH));
      wr_ok    = push_q & (~full | pop);
      ovf_d    = push_q & full & ~pop;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      head_d   = head_q;
      if (wr_ok && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!wr_ok && pop) begin
         count_d = count_q - CW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (count_d != '0) begin
         if (wr_ok && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_data_q;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         head_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem_q[wr_ptr_q] <= push_data_q;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= (count_d != '0);
         head_q     <= head_d;
         overflow_q <= ovf_d;
      end
   end

   assign valid     = valid_q;
   assign code      = head_q[7:0];
   assign released  = head_q[8];
   assign extended  = head_q[9];
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frames driven at the pins,
// outputs checked with immediate assertions.
module tb_ps2_scancode_rx;

   localparam int FL = 4;
   localparam int TO = 200;
   localparam int FD = 4;
   localparam int H  = 25;

   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       valid;
   logic [7:0] code;
   logic       released;
   logic       extended;
   logic       frame_err;
   logic       overflow;

   int tests = 0;
   int fails = 0;
   int ferr_cnt = 0;
   int ovf_cnt = 0;
   int e0;
   int o0;

   ps2_scancode_rx #(
      .FILTER_LEN(FL),
      .TIMEOUT   (TO),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk      (clk),
      .res_n    (res_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rd_en    (rd_en),
      .valid    (valid),
      .code     (code),
      .released (released),
      .extended (extended),
      .frame_err(frame_err),
      .overflow (overflow)
   );

   always #20 clk = ~clk;

   always @(posedge clk) begin
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      wait_cyc(H);
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
   endtask

   // mode 0: plain, 1: check valid latency, 2: pop on the write cycle
   task automatic send_frame(input logic [7:0] d, input logic par_flip,
                             input int mode);
      logic [10:0] f;
      f = {1'b1, (~^d) ^ par_flip, d, 1'b0};
      for (int i = 0; i < 10; i++) ps2_bit(f[i]);
      ps2_data = f[10];
      wait_cyc(H);
      ps2_clk = 1'b0;
      if (mode == 1) begin
         wait_cyc(FL + 3);
         chk("lat_pre", valid, 1'b0);
         wait_cyc(1);
         chk("lat_valid", valid, 1'b1);
         wait_cyc(H - FL - 4);
      end else if (mode == 2) begin
         wait_cyc(FL + 3);
         rd_en = 1'b1;
         wait_cyc(1);
         rd_en = 1'b0;
         wait_cyc(H - FL - 4);
      end else begin
         wait_cyc(H);
      end
      ps2_clk = 1'b1;
      wait_cyc(4 * H);
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] c,
                          input logic r, input logic e);
      chk({tag, "_valid"}, valid, 1'b1);
      chk({tag, "_code"}, code, c);
      chk({tag, "_rel"}, released, r);
      chk({tag, "_ext"}, extended, e);
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
   endtask

   initial begin
      wait_cyc(3);
      chk("rst_valid", valid, 1'b0);
      chk("rst_code", code, 8'h00);
      chk("rst_rel", released, 1'b0);
      chk("rst_ext", extended, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      res_n = 1'b1;
      wait_cyc(10);

      send_frame(8'h1C, 1'b0, 1);
      pop_chk("make", 8'h1C, 1'b0, 1'b0);
      chk("make_empty", valid, 1'b0);
      chk("make_hold", code, 8'h1C);
      chk("make_noerr", ferr_cnt, 0);

      send_frame(8'hE0, 1'b0, 0);
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h75, 1'b0, 0);
      pop_chk("extbrk", 8'h75, 1'b1, 1'b1);
      chk("extbrk_one", valid, 1'b0);
      send_frame(8'h1C, 1'b0, 0);
      pop_chk("after_eb", 8'h1C, 1'b0, 1'b0);

      e0 = ferr_cnt;
      send_frame(8'h1C, 1'b1, 0);
      chk("par_err", ferr_cnt, e0 + 1);
      chk("par_empty", valid, 1'b0);
      send_frame(8'hF0, 1'b1, 0);
      send_frame(8'h1C, 1'b0, 0);
      chk("badf0_err", ferr_cnt, e0 + 2);
      pop_chk("badf0", 8'h1C, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h1C, 1'b0, 0);
      pop_chk("goodf0", 8'h1C, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h1C, 1'b1, 0);
      send_frame(8'h1C, 1'b0, 0);
      pop_chk("errclr", 8'h1C, 1'b0, 1'b0);

      e0 = ferr_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_data = 1'b1;
      wait_cyc(TO + 10);
      chk("timeout_err", ferr_cnt, e0 + 1);
      chk("timeout_empty", valid, 1'b0);
      send_frame(8'h29, 1'b0, 0);
      pop_chk("recover", 8'h29, 1'b0, 1'b0);
      chk("recover_err", ferr_cnt, e0 + 1);

      o0 = ovf_cnt;
      send_frame(8'h1C, 1'b0, 0);
      send_frame(8'h32, 1'b0, 0);
      send_frame(8'h21, 1'b0, 0);
      send_frame(8'h23, 1'b0, 0);
      chk("full_noovf", ovf_cnt, o0);
      send_frame(8'h24, 1'b0, 0);
      chk("ovf_pulse", ovf_cnt, o0 + 1);
      pop_chk("ovf0", 8'h1C, 1'b0, 1'b0);
      pop_chk("ovf1", 8'h32, 1'b0, 1'b0);
      pop_chk("ovf2", 8'h21, 1'b0, 1'b0);
      pop_chk("ovf3", 8'h23, 1'b0, 1'b0);
      chk("ovf_empty", valid, 1'b0);

      o0 = ovf_cnt;
      send_frame(8'h1C, 1'b0, 0);
      send_frame(8'h32, 1'b0, 0);
      send_frame(8'h21, 1'b0, 0);
      send_frame(8'h23, 1'b0, 0);
      send_frame(8'h24, 1'b0, 2);
      chk("pp_noovf", ovf_cnt, o0);
      pop_chk("pp0", 8'h32, 1'b0, 1'b0);
      pop_chk("pp1", 8'h21, 1'b0, 1'b0);
      pop_chk("pp2", 8'h23, 1'b0, 1'b0);
      pop_chk("pp3", 8'h24, 1'b0, 1'b0);
      chk("pp_empty", valid, 1'b0);

      e0 = ferr_cnt;
      ps2_data = 1'b1;
      ps2_clk = 1'b0;
      wait_cyc(FL - 1);
      ps2_clk = 1'b1;
      wait_cyc(20);
      chk("glitch_short", ferr_cnt, e0);
      ps2_clk = 1'b0;
      wait_cyc(FL);
      ps2_clk = 1'b1;
      wait_cyc(20);
      chk("glitch_full", ferr_cnt, e0 + 1);

      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h1C, 1'b0, 0);
      chk("pre_rst_valid", valid, 1'b1);
      chk("pre_rst_rel", released, 1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      res_n = 1'b0;
      wait_cyc(2);
      chk("mrst_valid", valid, 1'b0);
      chk("mrst_code", code, 8'h00);
      chk("mrst_rel", released, 1'b0);
      chk("mrst_ext", extended, 1'b0);
      chk("mrst_ferr", frame_err, 1'b0);
      chk("mrst_ovf", overflow, 1'b0);
      res_n = 1'b1;
      wait_cyc(10);
      e0 = ferr_cnt;
      send_frame(8'h1C, 1'b0, 1);
      pop_chk("post_rst", 8'h1C, 1'b0, 1'b0);
      chk("post_rst_empty", valid, 1'b0);
      chk("post_rst_err", ferr_cnt, e0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
